qbus_slave_mem: RTL and testbench
=================================

# qbus_slave_mem

Synchronous Q-bus target (responder) for the 1801VP1 bench and FPGA builds. It decodes a word-aligned address window and serves DATI, DATO and DATOB cycles from a small internal register file. It also acts as an interrupt source with a daisy-chained IAK pass-through. It is the responder counterpart to the bus-master sequences that drive nSYNC, nDIN, nDOUT and nWTBT, and it answers with nRPLY.

## Interface
- BASE, 16'o172140: window base address; low AW+1 bits are zero.
- AW, 2: log2 of the number of 16-bit words in the window.
- RPLY_DLY, 2: clocks from synchronized strobe to nRPLY assertion, 1..7.
- VECTOR, 16'o000300: interrupt vector returned in the IAK cycle.

Ports (clock and reset first):
- PIN_CLK, in, 1: single clock; every flop is on its rising edge.
- PIN_RST, in, 1: reset, asynchronous and active-high.
- PIN_nAD_in, in, 16: inverted multiplexed address/data bus, as sampled.
- PIN_nAD_out, out, 16: inverted data to drive onto the bus.
- PIN_AD_oe, out, 1: active-high output enable for PIN_nAD_out.
- PIN_nSYNC, PIN_nDIN, PIN_nDOUT, PIN_nWTBT, in, 1 each: bus strobes, active-low, asynchronous to PIN_CLK.
- PIN_nRPLY, out, 1: reply, active-low.
- PIN_nIAKI, in, 1: interrupt acknowledge from upstream in the chain.
- PIN_nIAKO, out, 1: interrupt acknowledge to downstream in the chain.
- PIN_nVIRQ, out, 1: interrupt request, active-low.
- irq_set, in, 1: single-cycle pulse that sets the pending interrupt.

## Operation
- **Input stage:** all bus inputs pass through stage-1 registers. The strobes nSYNC, nDIN, nDOUT and nIAKI then pass through a second stage. All decisions use stage-2 strobes.
- **Address latch:** on the cycle stage-1 nSYNC goes from high to low, latch the following from stage-1:
  - address = ~nAD[15:0];
  - wtbt = ~nWTBT;
  - sel = (addr[15:AW+1] == BASE[15:AW+1]).
- **Master contract:** the master holds the address for at least one PIN_CLK period after nSYNC falls.
- **FSM states:** IDLE, ADDR, RDATA, WDATA, REPLY, HOLD, IAK.
- **IDLE:**
  - If sync2 is low, go to ADDR.
  - If sync2 is high, din2 is low, iaki2 is low and an interrupt is pending, go to IAK.
  - If sync2 is high, din2 is low, iaki2 is low and no interrupt is pending, drive PIN_nIAKO = 0 for as long as din2 and iaki2 both stay low.
- **ADDR:** if sel is 0, stay silent until sync2 rises, then return to IDLE. If sel is 1:
  - din2 low: go to RDATA.
  - dout2 low: go to WDATA.
- **RDATA:** after RPLY_DLY-1 wait clocks:
  - PIN_nAD_out = ~mem[addr[AW:1]];
  - PIN_AD_oe = 1;
  - one clock later, go to REPLY.
- **WDATA:** after RPLY_DLY-1 wait clocks, write stage-1 data to mem[addr[AW:1]], then go to REPLY.
  - Word write (wtbt = 0 at address, or nWTBT high in data phase): write all 16 bits.
  - Byte write (wtbt = 1 and stage-1 nWTBT low in data phase): addr[0] = 0 writes bits [7:0] from AD[7:0]; addr[0] = 1 writes bits [15:8] from AD[15:8].
- **REPLY:** PIN_nRPLY = 0, then go to HOLD.
- **HOLD:**
  - Keep nRPLY (and oe for a read) until the strobe (din2 or dout2) rises.
  - Then release nRPLY and oe on the next edge and go to IDLE.
- **IAK:**
  - Drive ~VECTOR with oe = 1 for one clock, then assert nRPLY.
  - Clear the pending interrupt on nRPLY assertion.
  - Stay in HOLD until din2 rises.
- **Interrupt:**
  - PIN_nVIRQ = ~pending.
  - irq_set in the same cycle as the clear has priority, so pending stays 1.
- **Abort:** sync2 rising in ADDR, RDATA, WDATA, REPLY or HOLD returns to IDLE. nRPLY and oe are released on that edge. A write that was not yet committed is dropped.

## Timing
- **Reset values:**
  - PIN_nRPLY = 1, PIN_AD_oe = 0, PIN_nAD_out = 16'hFFFF;
  - PIN_nIAKO = 1, PIN_nVIRQ = 1;
  - pending = 0, FSM in IDLE, mem = 0.
- **Reset mid-cycle:** all outputs return to their reset values immediately, without waiting for a clock edge.
- **Read latency:** 2 sync clocks + RPLY_DLY clocks from raw nDIN low to nRPLY low. Data becomes valid exactly one clock before nRPLY.
- **Release:** nRPLY goes high 3 clocks after raw nDIN or nDOUT rises (2 sync + 1). oe is released on the same edge.
- **Write order:** a write is committed before nRPLY goes low. Read-after-write to the same word returns the new data.
- **IAK pass-through:** PIN_nIAKO follows the synchronized nIAKI with a 2-clock lag and is never asserted while pending is 1.

## Structure
- **Package qbus_pkg:**
  - state enum (IDLE..IAK);
  - localparams for the stage count (2) and the RPLY_DLY range check;
  - function word_index(addr, AW).
- **Sub-module qbus_insync:** the stage-1/stage-2 input register bank. It outputs the stage-1 bus, the stage-1 nSYNC edge pulse, and the stage-2 strobes. It is instantiated once.
- **Register file:** a flop array inside qbus_slave_mem, with a byte-enable write.

## Test plan
- DATO word to 0o172142 with 0o123456, then DATI at 0o172142 → reads 0o123456. nRPLY falls 2+RPLY_DLY clocks after nDIN and rises 3 clocks after nDIN is released.
- DATOB to 0o172141 with data 0o111000 on the high lane, after 0o172140 was written with 0o000222 → DATI at 0o172140 reads 0o111222.
- DATI at 0o172200 (outside the window) → nRPLY and oe stay inactive for 32 clocks; the bench times out cleanly after nSYNC is released.
- irq_set pulse → nVIRQ = 0. IAK cycle (nDIN low, nIAKI low, nSYNC high) → vector 0o000300 read and nVIRQ = 1 after nRPLY. A second IAK with nothing pending → nIAKO = 0 and no nRPLY.
- PIN_RST asserted during HOLD of a read → nRPLY = 1 and oe = 0 immediately; the next DATI at 0o172140 reads 0.
- nSYNC released during the RDATA wait with RPLY_DLY = 5 → no nRPLY pulse, FSM back in IDLE; a subsequent cycle completes normally.

Source files
------------

// File: rtl/qbus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : qbus_pkg
//  Description : Shared types, constants and helpers for the Q-bus target.
//  Revision    : 1.0  initial release
// ============================================================================
package qbus_pkg;

    // Depth of the strobe synchronizer chain.
    localparam int c_SYNC_STAGES = 2;

    // Legal range of the reply delay; out-of-range values are clamped.
    localparam int c_RPLY_DLY_MIN = 1;
    localparam int c_RPLY_DLY_MAX = 7;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_RDATA = 3'd2,
        S_WDATA = 3'd3,
        S_REPLY = 3'd4,
        S_HOLD  = 3'd5,
        S_IAK   = 3'd6
    } state_t;

    // Kind of transfer in progress; selects which strobe ends HOLD.
    typedef enum logic [1:0] {
        K_READ  = 2'd0,
        K_WRITE = 2'd1,
        K_IAK   = 2'd2
    } kind_t;

    // Word index of a byte address inside a window of 2**aw words.
    function automatic int word_index(input logic [15:0] addr, input int aw);
        return int'(addr >> 1) & ((1 << aw) - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/qbus_slave_mem_if.sv
`default_nettype none
// ============================================================================
//  Module      : qbus_slave_mem_if
//  Description : Q-bus pin bundle between a bus master and the target.
//  Revision    : 1.0  initial release
// ============================================================================
interface qbus_slave_mem_if;

    logic [15:0] PIN_nAD_in;
    logic [15:0] PIN_nAD_out;
    logic        PIN_AD_oe;
    logic        PIN_nSYNC;
    logic        PIN_nDIN;
    logic        PIN_nDOUT;
    logic        PIN_nWTBT;
    logic        PIN_nRPLY;
    logic        PIN_nIAKI;
    logic        PIN_nIAKO;
    logic        PIN_nVIRQ;
    logic        irq_set;

    modport master (
        output PIN_nAD_in, PIN_nSYNC, PIN_nDIN, PIN_nDOUT, PIN_nWTBT,
               PIN_nIAKI, irq_set,
        input  PIN_nAD_out, PIN_AD_oe, PIN_nRPLY, PIN_nIAKO, PIN_nVIRQ
    );

    modport slave (
        input  PIN_nAD_in, PIN_nSYNC, PIN_nDIN, PIN_nDOUT, PIN_nWTBT,
               PIN_nIAKI, irq_set,
        output PIN_nAD_out, PIN_AD_oe, PIN_nRPLY, PIN_nIAKO, PIN_nVIRQ
    );

endinterface
`default_nettype wire

// File: rtl/qbus_insync.sv
`default_nettype none
// ============================================================================
//  Module      : qbus_insync
//  Description : Input register bank. Bus data and nWTBT get one stage,
//                strobes get c_SYNC_STAGES; also flags the nSYNC fall.
//  Revision    : 1.0  initial release
// ============================================================================
module qbus_insync
    import qbus_pkg::*;
(
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic [15:0] i_nad,
    input  wire logic        i_nsync,
    input  wire logic        i_ndin,
    input  wire logic        i_ndout,
    input  wire logic        i_nwtbt,
    input  wire logic        i_niaki,
    output logic      [15:0] o_nad1,
    output logic             o_nwtbt1,
    output logic             o_sync_fall,
    output logic             o_nsync2,
    output logic             o_ndin2,
    output logic             o_ndout2,
    output logic             o_niaki2
);

    logic [15:0] r_nad1;
    logic        r_nwtbt1;
    // Strobe bundle per stage: {nIAKI, nDOUT, nDIN, nSYNC}.
    logic [3:0]  r_strb [c_SYNC_STAGES];

    // Sample the raw pins and shift the strobes down the chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_nad1   <= 16'hFFFF;
            r_nwtbt1 <= 1'b1;
            for (int i = 0; i < c_SYNC_STAGES; i++) begin
                r_strb[i] <= 4'hF;
            end
        end else begin
            r_nad1    <= i_nad;
            r_nwtbt1  <= i_nwtbt;
            r_strb[0] <= {i_niaki, i_ndout, i_ndin, i_nsync};
            for (int i = 1; i < c_SYNC_STAGES; i++) begin
                r_strb[i] <= r_strb[i-1];
            end
        end
    end

    assign o_nad1      = r_nad1;
    assign o_nwtbt1    = r_nwtbt1;
    // Stage 1 low while the later stage still high: nSYNC just fell.
    assign o_sync_fall = r_strb[c_SYNC_STAGES-1][0] & ~r_strb[0][0];
    assign o_nsync2    = r_strb[c_SYNC_STAGES-1][0];
    assign o_ndin2     = r_strb[c_SYNC_STAGES-1][1];
    assign o_ndout2    = r_strb[c_SYNC_STAGES-1][2];
    assign o_niaki2    = r_strb[c_SYNC_STAGES-1][3];

endmodule
`default_nettype wire

// File: rtl/qbus_slave_mem.sv
`default_nettype none
// ============================================================================
//  Module      : qbus_slave_mem
//  Description : Q-bus target serving DATI/DATO/DATOB from a small register
//                file, plus a daisy-chained interrupt source.
//  Revision    : 1.0  initial release
// ============================================================================
module qbus_slave_mem
    import qbus_pkg::*;
#(
    parameter logic [15:0] BASE     = 16'o172140,
    parameter int          AW       = 2,
    parameter int          RPLY_DLY = 2,
    parameter logic [15:0] VECTOR   = 16'o000300
)(
    input  wire logic       PIN_CLK,
    input  wire logic       PIN_RST,
    qbus_slave_mem_if.slave bus
);

    localparam int         c_DLY   = (RPLY_DLY < c_RPLY_DLY_MIN) ? c_RPLY_DLY_MIN :
                                     (RPLY_DLY > c_RPLY_DLY_MAX) ? c_RPLY_DLY_MAX : RPLY_DLY;
    // Clocks spent in RDATA/WDATA; the last of them presents read data.
    localparam logic [2:0] c_WAIT  = 3'(c_DLY - 1);
    localparam int         c_WORDS = 1 << AW;

    logic [15:0] w_nad1;
    logic        w_nwtbt1, w_sync_fall, w_nsync2, w_ndin2, w_ndout2, w_niaki2;

    qbus_insync u_insync (
        .clk         (PIN_CLK),
        .rst         (PIN_RST),
        .i_nad       (bus.PIN_nAD_in),
        .i_nsync     (bus.PIN_nSYNC),
        .i_ndin      (bus.PIN_nDIN),
        .i_ndout     (bus.PIN_nDOUT),
        .i_nwtbt     (bus.PIN_nWTBT),
        .i_niaki     (bus.PIN_nIAKI),
        .o_nad1      (w_nad1),
        .o_nwtbt1    (w_nwtbt1),
        .o_sync_fall (w_sync_fall),
        .o_nsync2    (w_nsync2),
        .o_ndin2     (w_ndin2),
        .o_ndout2    (w_ndout2),
        .o_niaki2    (w_niaki2)
    );

    state_t      r_state, w_state_nxt;
    kind_t       r_kind, w_kind_nxt;
    logic [2:0]  r_cnt, w_cnt_nxt;
    logic [15:0] r_addr;
    logic        r_wtbt, r_sel, r_pending;
    logic [15:0] r_mem [c_WORDS];

    logic          w_we, w_clr_pend, w_abort, w_iak_req, w_oe;
    logic [1:0]    w_be;
    logic [15:0]   w_wdata, w_rdata;
    logic [AW-1:0] w_idx;

    assign w_idx     = AW'(word_index(r_addr, AW));
    assign w_wdata   = ~w_nad1;
    // IAK strobes are only meaningful while nSYNC is idle.
    assign w_iak_req = w_nsync2 & ~w_ndin2 & ~w_niaki2;
    // nSYNC going away cancels a data cycle; IAK runs with nSYNC high.
    assign w_abort   = w_nsync2 && (r_kind != K_IAK);
    // Byte lanes: a byte cycle needs wtbt at address time and nWTBT low now.
    assign w_be      = (r_wtbt && !w_nwtbt1) ? (r_addr[0] ? 2'b10 : 2'b01) : 2'b11;

    // Capture address, byte-mode flag and window hit at the start of a cycle.
    always_ff @(posedge PIN_CLK or posedge PIN_RST) begin
        if (PIN_RST) begin
            r_addr <= 16'h0000;
            r_wtbt <= 1'b0;
            r_sel  <= 1'b0;
        end else if (w_sync_fall) begin
            r_addr <= ~w_nad1;
            r_wtbt <= ~w_nwtbt1;
            r_sel  <= ((~w_nad1) >> (AW + 1)) == (BASE >> (AW + 1));
        end
    end

    // FSM state, transfer kind and wait counter registers.
    always_ff @(posedge PIN_CLK or posedge PIN_RST) begin
        if (PIN_RST) begin
            r_state <= S_IDLE;
            r_kind  <= K_READ;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_kind  <= w_kind_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic; also produces the write strobe and pending clear.
    always_comb begin
        w_state_nxt = r_state;
        w_kind_nxt  = r_kind;
        w_cnt_nxt   = r_cnt;
        w_we        = 1'b0;
        w_clr_pend  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_sync_fall) begin
                    w_state_nxt = S_ADDR;
                end else if (w_iak_req && r_pending) begin
                    w_state_nxt = S_IAK;
                    w_kind_nxt  = K_IAK;
                end
            end
            S_ADDR: begin
                if (w_nsync2) begin
                    w_state_nxt = S_IDLE;
                end else if (r_sel && !w_ndin2) begin
                    w_kind_nxt  = K_READ;
                    w_cnt_nxt   = c_WAIT;
                    w_state_nxt = (c_WAIT == 3'd0) ? S_REPLY : S_RDATA;
                end else if (r_sel && !w_ndout2) begin
                    w_kind_nxt  = K_WRITE;
                    w_cnt_nxt   = c_WAIT;
                    w_state_nxt = (c_WAIT == 3'd0) ? S_REPLY : S_WDATA;
                    w_we        = (c_WAIT == 3'd0);
                end
            end
            S_RDATA: begin
                if (w_abort) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt <= 3'd1) begin
                    w_state_nxt = S_REPLY;
                end else begin
                    w_cnt_nxt = r_cnt - 3'd1;
                end
            end
            S_WDATA: begin
                if (w_abort) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt <= 3'd1) begin
                    w_we        = 1'b1;
                    w_state_nxt = S_REPLY;
                end else begin
                    w_cnt_nxt = r_cnt - 3'd1;
                end
            end
            S_REPLY: begin
                w_state_nxt = w_abort ? S_IDLE : S_HOLD;
            end
            S_HOLD: begin
                if (w_abort) begin
                    w_state_nxt = S_IDLE;
                end else if ((r_kind == K_WRITE) ? w_ndout2 : w_ndin2) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_IAK: begin
                w_clr_pend  = 1'b1;
                w_state_nxt = S_REPLY;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Register file with per-byte write enables.
    always_ff @(posedge PIN_CLK or posedge PIN_RST) begin
        if (PIN_RST) begin
            for (int i = 0; i < c_WORDS; i++) begin
                r_mem[i] <= 16'h0000;
            end
        end else if (w_we) begin
            if (w_be[0]) r_mem[w_idx][7:0]  <= w_wdata[7:0];
            if (w_be[1]) r_mem[w_idx][15:8] <= w_wdata[15:8];
        end
    end

    // Pending interrupt; a new request wins over the acknowledge clear.
    always_ff @(posedge PIN_CLK or posedge PIN_RST) begin
        if (PIN_RST) begin
            r_pending <= 1'b0;
        end else if (bus.irq_set) begin
            r_pending <= 1'b1;
        end else if (w_clr_pend) begin
            r_pending <= 1'b0;
        end
    end

    // Outputs decode directly from registered state so reset clears them at once.
    assign w_oe    = ((r_state == S_RDATA) && (r_cnt == 3'd1)) ||
                     (r_state == S_IAK) ||
                     (((r_state == S_REPLY) || (r_state == S_HOLD)) && (r_kind != K_WRITE));
    assign w_rdata = (r_kind == K_IAK) ? VECTOR : r_mem[w_idx];

    assign bus.PIN_AD_oe   = w_oe;
    assign bus.PIN_nAD_out = w_oe ? ~w_rdata : 16'hFFFF;
    assign bus.PIN_nRPLY   = ~((r_state == S_REPLY) || (r_state == S_HOLD));
    assign bus.PIN_nVIRQ   = ~r_pending;
    assign bus.PIN_nIAKO   = ~((r_state == S_IDLE) && w_iak_req && !r_pending);

endmodule
`default_nettype wire

// File: tb/tb_qbus_slave_mem.sv
`default_nettype none
// ============================================================================
//  Module      : tb_qbus_slave_mem
//  Description : Directed bench for qbus_slave_mem. Two targets share one
//                stimulus bus: RPLY_DLY = 2 (main) and RPLY_DLY = 5.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_qbus_slave_mem;

    localparam int OP_WORD = 0;
    localparam int OP_BYTE = 1;
    localparam int OP_READ = 2;

    typedef struct {
        int          op;
        logic [15:0] addr;
        logic [15:0] data;   // write data, or expected read data
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] nad = 16'hFFFF;
    logic        nsync = 1'b1, ndin = 1'b1, ndout = 1'b1, nwtbt = 1'b1;
    logic        niaki = 1'b1, irq = 1'b0;
    logic        use5 = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    qbus_slave_mem_if bus2 ();
    qbus_slave_mem_if bus5 ();

    assign bus2.PIN_nAD_in = nad;
    assign bus2.PIN_nSYNC  = nsync;
    assign bus2.PIN_nDIN   = ndin;
    assign bus2.PIN_nDOUT  = ndout;
    assign bus2.PIN_nWTBT  = nwtbt;
    assign bus2.PIN_nIAKI  = niaki;
    assign bus2.irq_set    = irq;

    assign bus5.PIN_nAD_in = nad;
    assign bus5.PIN_nSYNC  = nsync;
    assign bus5.PIN_nDIN   = ndin;
    assign bus5.PIN_nDOUT  = ndout;
    assign bus5.PIN_nWTBT  = nwtbt;
    assign bus5.PIN_nIAKI  = 1'b1;
    assign bus5.irq_set    = 1'b0;

    qbus_slave_mem #(.BASE(16'o172140), .AW(2), .RPLY_DLY(2), .VECTOR(16'o000300)) u_dut2 (
        .PIN_CLK (clk),
        .PIN_RST (rst),
        .bus     (bus2)
    );

    qbus_slave_mem #(.BASE(16'o172140), .AW(2), .RPLY_DLY(5), .VECTOR(16'o000300)) u_dut5 (
        .PIN_CLK (clk),
        .PIN_RST (rst),
        .bus     (bus5)
    );

    logic        w_nrply, w_oe, w_niako, w_nvirq;
    logic [15:0] w_nad_out;
    assign w_nrply   = use5 ? bus5.PIN_nRPLY   : bus2.PIN_nRPLY;
    assign w_oe      = use5 ? bus5.PIN_AD_oe   : bus2.PIN_AD_oe;
    assign w_nad_out = use5 ? bus5.PIN_nAD_out : bus2.PIN_nAD_out;
    assign w_niako   = use5 ? bus5.PIN_nIAKO   : bus2.PIN_nIAKO;
    assign w_nvirq   = use5 ? bus5.PIN_nVIRQ   : bus2.PIN_nVIRQ;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One DATI/DATO/DATOB cycle. Times are clock counts from the data strobe
    // (or its release); -1 means the event never happened within the bound.
    task automatic bus_cycle(input int op, input logic [15:0] addr, input logic [15:0] data,
                             input int maxc, output logic [15:0] rd, output int t_oe,
                             output int t_rply, output int t_rel, output logic oe_rel);
        rd = 16'h0000; t_oe = -1; t_rply = -1; t_rel = -1; oe_rel = 1'b1;
        @(posedge clk); #1;
        nad   = ~addr;
        nwtbt = (op == OP_BYTE) ? 1'b0 : 1'b1;
        @(posedge clk); #1;
        nsync = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        if (op == OP_READ) begin
            nad = 16'hFFFF; nwtbt = 1'b1; ndin = 1'b0;
        end else begin
            nad = ~data; ndout = 1'b0;
        end
        for (int n = 1; n <= maxc; n++) begin
            @(posedge clk); #1;
            if (t_oe < 0 && w_oe) t_oe = n;
            if (!w_nrply) begin
                t_rply = n;
                rd     = ~w_nad_out;
                break;
            end
        end
        ndin = 1'b1; ndout = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk); #1;
            if (w_nrply) begin
                t_rel  = n;
                oe_rel = w_oe;
                break;
            end
        end
        nsync = 1'b1; nad = 16'hFFFF; nwtbt = 1'b1;
        repeat (6) @(posedge clk);
    endtask

    // Interrupt-acknowledge cycle; optionally fires irq_set on the clear edge.
    task automatic iak_cycle(input bit collide, input int maxc, output logic [15:0] rd,
                             output int t_rply, output int t_iako, output logic virq,
                             output int t_rel);
        rd = 16'h0000; t_rply = -1; t_iako = -1; virq = 1'bx; t_rel = -1;
        @(posedge clk); #1;
        ndin = 1'b0; niaki = 1'b0;
        for (int n = 1; n <= maxc; n++) begin
            @(posedge clk); #1;
            if (t_iako < 0 && !w_niako) t_iako = n;
            if (collide && n == 3) irq = 1'b1;
            if (collide && n == 4) irq = 1'b0;
            if (!w_nrply) begin
                t_rply = n;
                rd     = ~w_nad_out;
                virq   = w_nvirq;
                break;
            end
        end
        irq = 1'b0; ndin = 1'b1; niaki = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk); #1;
            if (w_nrply && w_niako) begin
                t_rel = n;
                break;
            end
        end
        repeat (4) @(posedge clk);
    endtask

    vec_t vecs [11];

    initial begin : main
        logic [15:0] rd;
        int          t_oe, t_rply, t_rel, t_iako;
        logic        oe_rel, virq, quiet;

        vecs[0]  = '{OP_WORD, 16'o172142, 16'o123456};
        vecs[1]  = '{OP_READ, 16'o172142, 16'o123456};
        vecs[2]  = '{OP_WORD, 16'o172140, 16'o000222};
        vecs[3]  = '{OP_BYTE, 16'o172141, 16'o111000};
        vecs[4]  = '{OP_READ, 16'o172140, 16'o111222};
        vecs[5]  = '{OP_WORD, 16'o172144, 16'o177777};
        vecs[6]  = '{OP_BYTE, 16'o172144, 16'o000000};
        vecs[7]  = '{OP_READ, 16'o172144, 16'o177400};
        vecs[8]  = '{OP_WORD, 16'o172146, 16'o000001};
        vecs[9]  = '{OP_READ, 16'o172146, 16'o000001};
        vecs[10] = '{OP_READ, 16'o172142, 16'o123456};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_nrply",  32'(w_nrply),   32'h1);
        chk("rst_oe",     32'(w_oe),      32'h0);
        chk("rst_nad",    32'(w_nad_out), 32'hFFFF);
        chk("rst_niako",  32'(w_niako),   32'h1);
        chk("rst_nvirq",  32'(w_nvirq),   32'h1);
        rst = 1'b0;
        repeat (3) @(posedge clk);

        // Table of data cycles against the RPLY_DLY = 2 target
        for (int i = 0; i < 11; i++) begin
            bus_cycle(vecs[i].op, vecs[i].addr, vecs[i].data, 40, rd, t_oe, t_rply, t_rel, oe_rel);
            chk($sformatf("v%0d_rply_lat", i), 32'(t_rply), 32'd4);
            chk($sformatf("v%0d_release", i),  32'(t_rel),  32'd3);
            if (vecs[i].op == OP_READ) begin
                chk($sformatf("v%0d_data", i),   32'(rd),     32'(vecs[i].data));
                chk($sformatf("v%0d_oe_lat", i), 32'(t_oe),   32'd3);
                chk($sformatf("v%0d_oe_rel", i), 32'(oe_rel), 32'h0);
            end
        end

        // Outside the window: nothing answers within 32 clocks
        bus_cycle(OP_READ, 16'o172200, 16'h0000, 32, rd, t_oe, t_rply, t_rel, oe_rel);
        chk("oow_no_rply", 32'(t_rply), 32'hFFFF_FFFF);
        chk("oow_no_oe",   32'(t_oe),   32'hFFFF_FFFF);

        // Interrupt: set, acknowledge with a colliding set, acknowledge, pass-through
        @(posedge clk); #1; irq = 1'b1;
        @(posedge clk); #1; irq = 1'b0;
        chk("irq_nvirq", 32'(w_nvirq), 32'h0);
        iak_cycle(1'b1, 16, rd, t_rply, t_iako, virq, t_rel);
        chk("iak1_rply",  32'(t_rply), 32'd4);
        chk("iak1_vec",   32'(rd),     32'o000300);
        chk("iak1_virq",  32'(virq),   32'h0);
        chk("iak1_niako", 32'(t_iako), 32'hFFFF_FFFF);
        iak_cycle(1'b0, 16, rd, t_rply, t_iako, virq, t_rel);
        chk("iak2_rply",  32'(t_rply), 32'd4);
        chk("iak2_vec",   32'(rd),     32'o000300);
        chk("iak2_virq",  32'(virq),   32'h1);
        chk("iak2_rel",   32'(t_rel),  32'd3);
        iak_cycle(1'b0, 12, rd, t_rply, t_iako, virq, t_rel);
        chk("iak3_no_rply", 32'(t_rply), 32'hFFFF_FFFF);
        chk("iak3_niako",   32'(t_iako), 32'd2);
        chk("iak3_rel",     32'(t_rel),  32'd2);

        // Reset while a read sits in HOLD
        @(posedge clk); #1;
        nad = ~16'o172140;
        @(posedge clk); #1;
        nsync = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        nad = 16'hFFFF; ndin = 1'b0;
        t_rply = -1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (!w_nrply) begin
                t_rply = n;
                break;
            end
        end
        chk("hold_rply", 32'(t_rply), 32'd4);
        repeat (2) @(posedge clk);
        #1;
        chk("hold_pre_oe", 32'(w_oe), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_nrply", 32'(w_nrply),   32'h1);
        chk("arst_oe",    32'(w_oe),      32'h0);
        chk("arst_nad",   32'(w_nad_out), 32'hFFFF);
        ndin = 1'b1; nsync = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        bus_cycle(OP_READ, 16'o172140, 16'h0000, 40, rd, t_oe, t_rply, t_rel, oe_rel);
        chk("post_rst_data", 32'(rd),     32'h0);
        chk("post_rst_rply", 32'(t_rply), 32'd4);

        // RPLY_DLY = 5 target: abort inside the RDATA wait, then normal cycles
        use5 = 1'b1;
        @(posedge clk); #1;
        nad = ~16'o172146;
        @(posedge clk); #1;
        nsync = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        nad = 16'hFFFF; ndin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        nsync = 1'b1; ndin = 1'b1;
        quiet = 1'b1;
        for (int n = 0; n < 15; n++) begin
            @(posedge clk); #1;
            if (!w_nrply || w_oe) quiet = 1'b0;
        end
        chk("abort_quiet", 32'(quiet), 32'h1);
        bus_cycle(OP_WORD, 16'o172146, 16'o052525, 40, rd, t_oe, t_rply, t_rel, oe_rel);
        chk("d5_wr_rply", 32'(t_rply), 32'd7);
        chk("d5_wr_rel",  32'(t_rel),  32'd3);
        bus_cycle(OP_READ, 16'o172146, 16'h0000, 40, rd, t_oe, t_rply, t_rel, oe_rel);
        chk("d5_rd_data", 32'(rd),     32'o052525);
        chk("d5_rd_oe",   32'(t_oe),   32'd6);
        chk("d5_rd_rply", 32'(t_rply), 32'd7);
        chk("d5_rd_rel",  32'(t_rel),  32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
